bufg_gt_ctrl: RTL and testbench

Control sequencer that drives the CE, CLR and DIV inputs of a GT clock buffer so the divided clock can be started, stopped and re-ratioed without glitches or runt pulses. It sits directly upstream of the GT clock buffer and runs on the same free-running source clock the buffer divides. Divider changes are requested over a valid/ready handshake. Every start and every ratio change goes through a fixed drain/clear/settle sequence.

---
 rtl/bufg_gt_ctrl.sv | 157 +++++++++++++++
 tb/tb_bufg_gt_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bufg_gt_ctrl.sv
// Glitch-free start/stop/re-ratio sequencer for a GT clock buffer (CE/CLR/DIV).
// Optional status counter of CLEAR entries: define BUFG_GT_CTRL_STATUS_EN.
module bufg_gt_ctrl #(
    parameter int         DRAIN_CYCLES  = 8,
    parameter int         CLR_CYCLES    = 3,
    parameter int         SETTLE_CYCLES = 4,
    parameter logic [2:0] INIT_DIV      = 3'd0
) (
    input  logic       I,
    input  logic       CLR,
    input  logic       en,
    input  logic       cfg_valid,
    input  logic [2:0] cfg_div,
    output logic       cfg_ready,
    output logic       CE_O,
    output logic       CLR_O,
    output logic [2:0] DIV_O,
    output logic       running
`ifdef BUFG_GT_CTRL_STATUS_EN
    ,
    output logic [7:0] reconfig_cnt
`endif
);

    localparam int MAX_A = (DRAIN_CYCLES > CLR_CYCLES) ? DRAIN_CYCLES : CLR_CYCLES;
    localparam int MAX_P = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
    localparam int CW    = (MAX_P < 1) ? 1 : $clog2(MAX_P + 1);

    localparam logic [CW-1:0] DRAIN_LD  = CW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] CLR_LD    = CW'(CLR_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        STOP   = 3'd0,
        RUN    = 3'd1,
        DRAIN  = 3'd2,
        CLEAR  = 3'd3,
        SETTLE = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    pending;
    logic          restart;
    logic          accept;

    assign accept = cfg_valid & cfg_ready;

    always_ff @(posedge I or posedge CLR) begin
        if (CLR) begin
            state     <= STOP;
            CE_O      <= 1'b0;
            CLR_O     <= 1'b0;
            DIV_O     <= INIT_DIV;
            cfg_ready <= 1'b1;
            running   <= 1'b0;
            restart   <= 1'b0;
            pending   <= INIT_DIV;
            cnt       <= '0;
        end else begin
            case (state)
                STOP: begin
                    if (accept)
                        DIV_O <= cfg_div;
                    if (en) begin
                        state     <= CLEAR;
                        CLR_O     <= 1'b1;
                        cfg_ready <= 1'b0;
                        cnt       <= CLR_LD;
                    end
                end
                RUN: begin
                    // A request together with en=0 always forces the full clear sequence.
                    if (accept && (!en || cfg_div != DIV_O)) begin
                        state     <= DRAIN;
                        pending   <= cfg_div;
                        restart   <= 1'b1;
                        CE_O      <= 1'b0;
                        running   <= 1'b0;
                        cfg_ready <= 1'b0;
                        cnt       <= DRAIN_LD;
                    end else if (!en) begin
                        state     <= DRAIN;
                        restart   <= 1'b0;
                        CE_O      <= 1'b0;
                        running   <= 1'b0;
                        cfg_ready <= 1'b0;
                        cnt       <= DRAIN_LD;
                    end
                end
                DRAIN: begin
                    if (cnt == '0) begin
                        if (restart) begin
                            state <= CLEAR;
                            CLR_O <= 1'b1;
                            DIV_O <= pending;
                            cnt   <= CLR_LD;
                        end else begin
                            state     <= STOP;
                            cfg_ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == '0) begin
                        state   <= SETTLE;
                        CLR_O   <= 1'b0;
                        restart <= 1'b0;
                        cnt     <= SETTLE_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        cfg_ready <= 1'b1;
                        if (en) begin
                            state   <= RUN;
                            CE_O    <= 1'b1;
                            running <= 1'b1;
                        end else begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= STOP;
                    CE_O      <= 1'b0;
                    CLR_O     <= 1'b0;
                    cfg_ready <= 1'b1;
                    running   <= 1'b0;
                    restart   <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end

`ifdef BUFG_GT_CTRL_STATUS_EN
    logic clear_entry;

    assign clear_entry = ((state == STOP) && en) ||
                         ((state == DRAIN) && (cnt == '0) && restart);

    always_ff @(posedge I or posedge CLR) begin
        if (CLR)
            reconfig_cnt <= 8'd0;
        else if (clear_entry && reconfig_cnt != 8'hFF)
            reconfig_cnt <= reconfig_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_bufg_gt_ctrl.sv
// Directed bench for bufg_gt_ctrl with default parameters (D=8, C=3, S=4).
module tb_bufg_gt_ctrl;

    logic       I = 1'b0;
    logic       CLR;
    logic       en;
    logic       cfg_valid;
    logic [2:0] cfg_div;
    logic       cfg_ready;
    logic       CE_O;
    logic       CLR_O;
    logic [2:0] DIV_O;
    logic       running;
`ifdef BUFG_GT_CTRL_STATUS_EN
    logic [7:0] reconfig_cnt;
`endif

    int vectors    = 0;
    int miscompares = 0;

    bufg_gt_ctrl dut (
        .I         (I),
        .CLR       (CLR),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .CE_O      (CE_O),
        .CLR_O     (CLR_O),
        .DIV_O     (DIV_O),
        .running   (running)
`ifdef BUFG_GT_CTRL_STATUS_EN
        ,
        .reconfig_cnt (reconfig_cnt)
`endif
    );

    always #5 I = ~I;

    task automatic step();
        @(posedge I);
        #1;
    endtask

    // Expected packed as {CLR_O, CE_O, running, cfg_ready, DIV_O}
    task automatic chk(input string tag, input logic [6:0] exp_v);
        logic [6:0] obs;
        obs = {CLR_O, CE_O, running, cfg_ready, DIV_O};
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic chk_n(input string tag, input int n, input logic [6:0] exp_v);
        for (int i = 0; i < n; i++) begin
            step();
            chk(tag, exp_v);
        end
    endtask

    initial begin
        CLR = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = 3'd0;
        step();
        step();
        chk("reset", 7'b0001_000);
        CLR = 1'b0;
        step();
        chk("idle_stop", 7'b0001_000);

        // Start from STOP
        en = 1'b1;
        chk_n("start_clear", 3, 7'b1000_000);
        chk_n("start_settle", 4, 7'b0000_000);
        chk_n("start_run", 1, 7'b0111_000);

        // Reconfig 0 -> 3
        cfg_valid = 1'b1; cfg_div = 3'd3;
        step();
        chk("rc3_accept", 7'b0000_000);
        cfg_valid = 1'b0;
        chk_n("rc3_drain", 7, 7'b0000_000);
        chk_n("rc3_clear", 3, 7'b1000_011);
        chk_n("rc3_settle", 4, 7'b0000_011);
        chk_n("rc3_run", 1, 7'b0111_011);

        // Same divider: handshake only
        cfg_valid = 1'b1; cfg_div = 3'd3;
        step();
        chk("same_div", 7'b0111_011);
        cfg_valid = 1'b0;
        chk_n("same_div_hold", 3, 7'b0111_011);

        // Request held valid across the whole sequence: one restart only
        cfg_valid = 1'b1; cfg_div = 3'd5;
        step();
        chk("rc5_accept", 7'b0000_011);
        chk_n("rc5_drain", 7, 7'b0000_011);
        chk_n("rc5_clear", 3, 7'b1000_101);
        chk_n("rc5_settle", 4, 7'b0000_101);
        chk_n("rc5_run", 1, 7'b0111_101);
        chk_n("rc5_reaccept_same", 2, 7'b0111_101);
        cfg_valid = 1'b0;

        // en=0 with a request in the same cycle
        en = 1'b0; cfg_valid = 1'b1; cfg_div = 3'd7;
        step();
        chk("stopreq_accept", 7'b0000_101);
        cfg_valid = 1'b0;
        chk_n("stopreq_drain", 7, 7'b0000_101);
        chk_n("stopreq_clear", 3, 7'b1000_111);
        chk_n("stopreq_settle", 4, 7'b0000_111);
        chk_n("stopreq_stop", 2, 7'b0001_111);

        // Start with a request in the same STOP cycle
        en = 1'b1; cfg_valid = 1'b1; cfg_div = 3'd2;
        step();
        chk("start_req_clear0", 7'b1000_010);
        cfg_valid = 1'b0;
        chk_n("start_req_clear", 2, 7'b1000_010);
        chk_n("start_req_settle", 4, 7'b0000_010);
        chk_n("start_req_run", 1, 7'b0111_010);

        // Plain stop
        en = 1'b0;
        step();
        chk("stop_drain0", 7'b0000_010);
        chk_n("stop_drain", 7, 7'b0000_010);
        chk_n("stop_stop", 2, 7'b0001_010);

        // Async CLR during CLEAR of a reconfig
        en = 1'b1;
        chk_n("pre_clr_clear", 3, 7'b1000_010);
        chk_n("pre_clr_settle", 4, 7'b0000_010);
        chk_n("pre_clr_run", 1, 7'b0111_010);
        cfg_valid = 1'b1; cfg_div = 3'd6;
        step();
        cfg_valid = 1'b0;
        chk_n("pre_clr_drain", 7, 7'b0000_010);
        chk_n("pre_clr_in_clear", 2, 7'b1000_110);
        #2;
        CLR = 1'b1;
        #1;
        chk("async_clr", 7'b0001_000);
        en = 1'b0;
        step();
        CLR = 1'b0;
        chk_n("after_clr_stop", 3, 7'b0001_000);

`ifdef BUFG_GT_CTRL_STATUS_EN
        vectors++;
        assert (reconfig_cnt === 8'd0) else begin
            miscompares++;
            $error("FAIL cnt_reset: observed %0d expected 0", reconfig_cnt);
        end
        en = 1'b1;
        chk_n("cnt_start_clear", 3, 7'b1000_000);
        chk_n("cnt_start_settle", 4, 7'b0000_000);
        chk_n("cnt_start_run", 1, 7'b0111_000);
        vectors++;
        assert (reconfig_cnt === 8'd1) else begin
            miscompares++;
            $error("FAIL cnt_one: observed %0d expected 1", reconfig_cnt);
        end
        for (int i = 0; i < 300; i++) begin
            cfg_valid = 1'b1;
            cfg_div = (i % 2 == 0) ? 3'd1 : 3'd2;
            step();
            cfg_valid = 1'b0;
            for (int j = 0; j < 15; j++) step();
        end
        chk("cnt_loop_run", 7'b0111_010);
        vectors++;
        assert (reconfig_cnt === 8'd255) else begin
            miscompares++;
            $error("FAIL cnt_saturate: observed %0d expected 255", reconfig_cnt);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
